// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aes_pkg
//  Purpose  : Shared AES types, GF(2^8) arithmetic, S-box helpers and RCON.
//  Revision : 1.0  initial release
// ============================================================================
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        KEYEXP   = 3'd1,
        INIT_ARK = 3'd2,
        ROUND    = 3'd3,
        DONE     = 3'd4
    } dec_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) acc = gmul(acc, sq);
            sq = gmul(sq, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_decrypt_iter_if.sv
`default_nettype none
// ============================================================================
//  Module   : aes_decrypt_iter_if
//  Purpose  : Valid/ready block interface of the iterative AES-128 decryptor.
//  Revision : 1.0  initial release
// ============================================================================
interface aes_decrypt_iter_if;
    import aes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t ciphertext;
    state_t key;
    logic   out_valid;
    logic   out_ready;
    state_t plaintext;

    modport master (
        output in_valid, ciphertext, key, out_ready,
        input  in_ready, out_valid, plaintext
    );

    modport slave (
        input  in_valid, ciphertext, key, out_ready,
        output in_ready, out_valid, plaintext
    );

endinterface
`default_nettype wire

// File: rtl/aes_inv_round.sv
`default_nettype none
// ============================================================================
//  Module   : aes_inv_round
//  Purpose  : Combinational AES inverse round; InvMixColumns bypassed on last.
//  Revision : 1.0  initial release
// ============================================================================
module aes_inv_round
    import aes_pkg::*;
(
    input  state_t st,
    input  state_t rk,
    input  logic   last,
    output state_t next_st
);

    logic [7:0] w_a [16];

    always_comb begin
        next_st = '0;
        // Byte i sits at row i%4, column i/4; InvShiftRows pulls from column (c-r) mod 4.
        for (int i = 0; i < 16; i++) begin
            w_a[i] = inv_sbox(st[127 - 8 * ((((i / 4) - (i % 4) + 4) % 4) * 4 + (i % 4)) -: 8])
                   ^ rk[127 - 8 * i -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            if (last) begin
                next_st[127 - 32 * c -: 32] = {w_a[4*c], w_a[4*c+1], w_a[4*c+2], w_a[4*c+3]};
            end else begin
                next_st[127 - 32 * c -: 32] = {
                    gmul(w_a[4*c], 8'h0e) ^ gmul(w_a[4*c+1], 8'h0b) ^ gmul(w_a[4*c+2], 8'h0d) ^ gmul(w_a[4*c+3], 8'h09),
                    gmul(w_a[4*c], 8'h09) ^ gmul(w_a[4*c+1], 8'h0e) ^ gmul(w_a[4*c+2], 8'h0b) ^ gmul(w_a[4*c+3], 8'h0d),
                    gmul(w_a[4*c], 8'h0d) ^ gmul(w_a[4*c+1], 8'h09) ^ gmul(w_a[4*c+2], 8'h0e) ^ gmul(w_a[4*c+3], 8'h0b),
                    gmul(w_a[4*c], 8'h0b) ^ gmul(w_a[4*c+1], 8'h0d) ^ gmul(w_a[4*c+2], 8'h09) ^ gmul(w_a[4*c+3], 8'h0e)
                };
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_decrypt_iter.sv
`default_nettype none
// ============================================================================
//  Module   : aes_decrypt_iter
//  Purpose  : Iterative AES-128 inverse cipher, one round per clock, with the
//             key schedule walked forward then unwound on the fly.
//  Revision : 1.0  initial release
// ============================================================================
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter int NR = 10
)
(
    input  logic              clk,
    input  logic              rst,
    aes_decrypt_iter_if.slave bus
);

    if (NR != 10) begin : g_nr_check
        $error("aes_decrypt_iter: NR must be 10 for AES-128");
    end

    dec_state_e r_state, w_state_nxt;
    state_t     r_st, w_st_nxt;
    state_t     r_rk, w_rk_nxt;
    logic [3:0] r_rnd, w_rnd_nxt;
    state_t     r_pt, w_pt_nxt;
    logic       r_out_valid, w_out_valid_nxt;
    state_t     w_round_out;
    logic       w_last;

    function automatic state_t expand(input state_t rk, input logic [7:0] rc);
        word_t w0, w1, w2, w3;
        w0 = rk[127:96] ^ sub_word(rot_word(rk[31:0])) ^ {rc, 24'h0};
        w1 = rk[95:64] ^ w0;
        w2 = rk[63:32] ^ w1;
        w3 = rk[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Inverse of expand: recover the later words first, then w0 from the recovered w3.
    function automatic state_t unexpand(input state_t rk, input logic [7:0] rc);
        word_t w0, w1, w2, w3;
        w3 = rk[31:0]  ^ rk[63:32];
        w2 = rk[63:32] ^ rk[95:64];
        w1 = rk[95:64] ^ rk[127:96];
        w0 = rk[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    assign w_last = (r_rnd == 4'd0);

    aes_inv_round u_inv_round (
        .st      (r_st),
        .rk      (r_rk),
        .last    (w_last),
        .next_st (w_round_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_st        <= '0;
            r_rk        <= '0;
            r_rnd       <= '0;
            r_pt        <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_st        <= w_st_nxt;
            r_rk        <= w_rk_nxt;
            r_rnd       <= w_rnd_nxt;
            r_pt        <= w_pt_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_st_nxt        = r_st;
        w_rk_nxt        = r_rk;
        w_rnd_nxt       = r_rnd;
        w_pt_nxt        = r_pt;
        w_out_valid_nxt = r_out_valid;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_st_nxt    = bus.ciphertext;
                    w_rk_nxt    = bus.key;
                    w_rnd_nxt   = 4'd1;
                    w_state_nxt = KEYEXP;
                end
            end
            KEYEXP: begin
                w_rk_nxt  = expand(r_rk, rcon(r_rnd));
                w_rnd_nxt = r_rnd + 4'd1;
                if (r_rnd == 4'(NR)) w_state_nxt = INIT_ARK;
            end
            INIT_ARK: begin
                w_st_nxt    = r_st ^ r_rk;
                w_rk_nxt    = unexpand(r_rk, rcon(4'(NR)));
                w_rnd_nxt   = 4'(NR - 1);
                w_state_nxt = ROUND;
            end
            ROUND: begin
                if (w_last) begin
                    w_pt_nxt        = w_round_out;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = DONE;
                end else begin
                    w_st_nxt  = w_round_out;
                    w_rk_nxt  = unexpand(r_rk, rcon(r_rnd));
                    w_rnd_nxt = r_rnd - 4'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.plaintext = r_pt;

endmodule
`default_nettype wire

// File: tb/tb_aes_decrypt_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_decrypt_iter
//  Purpose  : Directed FIPS-197 vector bench for aes_decrypt_iter.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_aes_decrypt_iter;
    import aes_pkg::*;

    localparam state_t C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam state_t C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam state_t C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam state_t B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam state_t B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam state_t B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    aes_decrypt_iter_if bus_if ();

    aes_decrypt_iter #(.NR(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; poke keeps driving junk while the block is busy.
    task automatic run_txn(input state_t ct, input state_t key, input state_t exp,
                           input int bp_cycles, input bit poke);
        int cnt;
        bit busy_ok;
        check_val("pre_ready", 128'(bus_if.in_ready), 128'd1);
        bus_if.in_valid   = 1'b1;
        bus_if.ciphertext = ct;
        bus_if.key        = key;
        bus_if.out_ready  = 1'b0;
        tick();
        if (poke) begin
            bus_if.ciphertext = '1;
            bus_if.key        = '0;
        end else begin
            bus_if.in_valid = 1'b0;
        end
        cnt     = 0;
        busy_ok = 1'b1;
        while (bus_if.out_valid !== 1'b1 && cnt < 40) begin
            if (bus_if.in_ready !== 1'b0) busy_ok = 1'b0;
            tick();
            cnt++;
        end
        bus_if.in_valid = 1'b0;
        check_val("latency", 128'(cnt), 128'd21);
        check_val("busy_ready_low", 128'(busy_ok), 128'd1);
        check_val("plaintext", bus_if.plaintext, exp);
        check_val("done_ready", 128'(bus_if.in_ready), 128'd0);
        for (int k = 0; k < bp_cycles; k++) begin
            tick();
            check_val("bp_valid", 128'(bus_if.out_valid), 128'd1);
            check_val("bp_plaintext", bus_if.plaintext, exp);
            check_val("bp_ready", 128'(bus_if.in_ready), 128'd0);
        end
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
        check_val("post_valid", 128'(bus_if.out_valid), 128'd0);
        check_val("post_ready", 128'(bus_if.in_ready), 128'd1);
        check_val("post_plaintext", bus_if.plaintext, exp);
    endtask

    task automatic back_to_back();
        int e, acc1, ov1, hs1, acc2, ov2;
        bit rdy_b, ov_b;
        state_t pt1, pt2;
        e = 0; acc1 = -1; ov1 = -1; hs1 = -1; acc2 = -1; ov2 = -1;
        pt1 = '0; pt2 = '0;
        bus_if.in_valid   = 1'b1;
        bus_if.ciphertext = C1_CT;
        bus_if.key        = C1_KEY;
        bus_if.out_ready  = 1'b1;
        while (e < 80 && ov2 < 0) begin
            rdy_b = bus_if.in_ready;
            ov_b  = bus_if.out_valid;
            tick();
            e++;
            if (rdy_b && bus_if.in_valid) begin
                if (acc1 < 0) begin
                    acc1 = e;
                    bus_if.ciphertext = B_CT;
                    bus_if.key        = B_KEY;
                end else if (acc2 < 0) begin
                    acc2 = e;
                end
            end
            if (ov_b && bus_if.out_ready && hs1 < 0) hs1 = e;
            if (bus_if.out_valid === 1'b1) begin
                if (ov1 < 0) begin
                    ov1 = e;
                    pt1 = bus_if.plaintext;
                end else if (acc2 >= 0 && ov2 < 0) begin
                    ov2 = e;
                    pt2 = bus_if.plaintext;
                end
            end
        end
        bus_if.in_valid = 1'b0;
        tick();
        bus_if.out_ready = 1'b0;
        check_val("b2b_lat1", 128'(ov1 - acc1), 128'd21);
        check_val("b2b_pt1", pt1, C1_PT);
        check_val("b2b_gap", 128'(acc2 - hs1), 128'd1);
        check_val("b2b_lat2", 128'(ov2 - acc2), 128'd21);
        check_val("b2b_pt2", pt2, B_PT);
        check_val("b2b_idle", 128'(bus_if.in_ready), 128'd1);
    endtask

    initial begin
        bus_if.in_valid   = 1'b0;
        bus_if.ciphertext = '0;
        bus_if.key        = '0;
        bus_if.out_ready  = 1'b0;

        #12;
        check_val("rst_ready", 128'(bus_if.in_ready), 128'd1);
        check_val("rst_valid", 128'(bus_if.out_valid), 128'd0);
        check_val("rst_plaintext", bus_if.plaintext, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_txn(C1_CT, C1_KEY, C1_PT, 0, 1'b0);
        run_txn(B_CT, B_KEY, B_PT, 5, 1'b0);
        run_txn(C1_CT, C1_KEY, C1_PT, 0, 1'b1);
        back_to_back();

        // Abort part-way through the key expansion with an unaligned reset.
        bus_if.in_valid   = 1'b1;
        bus_if.ciphertext = C1_CT;
        bus_if.key        = C1_KEY;
        tick();
        bus_if.in_valid = 1'b0;
        repeat (8) tick();
        #3;
        rst = 1'b1;
        #1;
        check_val("abort_valid", 128'(bus_if.out_valid), 128'd0);
        check_val("abort_ready", 128'(bus_if.in_ready), 128'd1);
        check_val("abort_plaintext", bus_if.plaintext, 128'd0);
        #2;
        rst = 1'b0;
        tick();
        run_txn(C1_CT, C1_KEY, C1_PT, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
